// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] HL_WRITE_BOTH = 2'b11;
  localparam logic [1:0] HL_WRITE_NONE = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage side of the multiply/divide unit plus its Hi/Lo write port.
interface mul_div_unit_if import mul_div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] dinHi;
  logic [WIDTH-1:0] dinLo;
  logic [1:0]       hlWrite;

  modport master (
    output start, op, srcA, srcB, flush,
    input  busy, dinHi, dinLo, hlWrite
  );

  modport slave (
    input  start, op, srcA, srcB, flush,
    output busy, dinHi, dinLo, hlWrite
  );

endinterface

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mul_div_unit_div_step import mul_div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Top bit of the difference is the borrow: set means restore.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, div_i};
    qbit_o  = ~diff[WIDTH+1];
    rem_o   = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine driving the Hi/Lo register write port.
// Define MUL_DIV_FAST_MUL_EN for a single-cycle combinational multiply.
module mul_div_unit import mul_div_unit_pkg::*; #(
  parameter int unsigned WIDTH = DATA_W
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;
  logic [WIDTH:0]     rem_nxt;
  logic               qbit;

  // Divisor sits in opnd_q; the dividend shifts out of acc_q's low half as quotient bits enter.
  mul_div_unit_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (rem_q),
    .bit_i  (acc_q[WIDTH-1]),
    .div_i  (opnd_q),
    .rem_o  (rem_nxt),
    .qbit_o (qbit)
  );

  // Operand magnitudes, shift-add partial sum and sign-corrected results.
  always_comb begin
    sign_a  = ~bus.op[0] & bus.srcA[WIDTH-1];
    sign_b  = ~bus.op[0] & bus.srcB[WIDTH-1];
    mag_a   = sign_a ? -bus.srcA : bus.srcA;
    mag_b   = sign_b ? -bus.srcB : bus.srcB;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    prod    = neg_quo_q ? -acc_q : acc_q;
    quo     = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd     = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // Next-state logic; flush overrides everything and blocks the FIX result load.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d  = bus.op[1];
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          rem_d     = '0;
          cnt_d     = CntLoad;
          if (bus.op[1]) begin
            opnd_d  = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = StDiv;
          end else begin
`ifdef MUL_DIV_FAST_MUL_EN
            acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
            state_d = StFix;
`else
            opnd_d  = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = StMul;
`endif
          end
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = StFix;
      end
      StDiv: begin
        rem_d = rem_nxt;
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rmd;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.hlWrite = (state_q == StDone && !bus.flush) ? HL_WRITE_BOTH : HL_WRITE_NONE;
  assign bus.dinHi   = hi_q;
  assign bus.dinLo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide engine for MULT, MULTU, DIV and DIVU.
- It is the writer side of the Hi/Lo register pair. It drives that pair's dinHi/dinLo/hlWrite inputs and returns the product (Hi:Lo) or remainder/quotient (Hi/Lo).
- Sits in the execute stage. `busy` stalls the pipeline so MFHI/MFLO and new mul/div ops wait until the write has been issued.

Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- clk      input   1      clock, all state updates on rising edge
- rst      input   1      synchronous, active-low reset (0 = reset), sampled on rising edge of clk
- start    input   1      launch operation; sampled only in IDLE
- op       input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start
- srcA     input   WIDTH  multiplicand / dividend (rs); captured with start
- srcB     input   WIDTH  multiplier / divisor (rt); captured with start
- flush    input   1      abort current operation (exception/branch flush)
- busy     output  1      high whenever state != IDLE
- dinHi    output  WIDTH  Hi result (product high half / remainder)
- dinLo    output  WIDTH  Lo result (product low half / quotient)
- hlWrite  output  2      {Hi write, Lo write}; 2'b11 for one cycle in DONE, else 2'b00

Behaviour:
- States: IDLE, MUL, DIV, FIX, DONE.
- Reset (rst=0 at edge):
  - state goes to IDLE; busy=0, hlWrite=00, dinHi=0, dinLo=0, iteration counter=0.
  - Reset mid-operation discards the operation; no write is issued.
- IDLE:
  - start=1 captures op, srcA, srcB and takes magnitudes for signed ops.
  - Next state is MUL (op[1]=0) or DIV (op[1]=1); counter loads WIDTH.
  - start=0 stays IDLE.
- MUL: radix-2 shift-add, one bit per cycle on a 2*WIDTH accumulator; counter decrements. At counter==1 go to FIX.
- DIV: restoring division, one quotient bit per cycle; remainder register WIDTH+1 bits. At counter==1 go to FIX.
- FIX (1 cycle), sign correction:
  - MULT: negate the 64-bit product if srcA[31]^srcB[31].
  - DIV: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Result is registered into dinHi/dinLo. Next state is DONE.
- DONE (1 cycle): hlWrite=11, busy=1. Next state is IDLE.
- Latency: start sampled at edge E0 → iterations occupy cycles 1..32, FIX cycle 33, DONE cycle 34. Hi/Lo update at the end of cycle 34; busy falls in cycle 35.
- busy: 1 in MUL/DIV/FIX/DONE. start while busy is ignored; there is no queueing.
- dinHi/dinLo hold their last value outside DONE.
- Divide by zero:
  - Completes in normal latency.
  - DIVU: Lo=0xFFFFFFFF, Hi=srcA.
  - DIV: Lo=0xFFFFFFFF if srcA>=0 else 0x00000001, Hi=srcA.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (natural result of magnitude algorithm plus FIX; no special case needed beyond WIDTH+1 remainder).
- flush:
  - flush=1 in any state returns to IDLE next edge and suppresses hlWrite in that cycle (combinationally gated).
  - flush and start together in IDLE: flush wins, nothing launches.
- Reset has priority over flush, flush over start.

Optional Feature:
- Macro: MUL_DIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiply.
  - IDLE→FIX directly (start at E0, FIX cycle 1, DONE cycle 2, hlWrite in cycle 2).
  - MUL state is unreachable.
  - Division is unchanged.
- Not defined: iterative multiply as above; no multiplier macro is instantiated.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - state encodings.
  - HL_WRITE_BOTH=2'b11, HL_WRITE_NONE=2'b00.
  - DATA_W=32.
- One natural sub-module: div_step, a combinational restoring-division step. Inputs are partial remainder, dividend bit and divisor; outputs are the next remainder and the quotient bit. It is shared by a single instance.

Test Plan:
- Reset mid-operation:
  - Stimulus: MULTU 0x00000003×0x00000005, then rst=0 at cycle 10.
  - Response: busy=0 next cycle; hlWrite never 11; dinHi=dinLo=0.
- MULT:
  - Stimulus: 0xFFFFFFFE (−2) × 0x00000007.
  - Response: in cycle 34 hlWrite=11, Hi=0xFFFFFFFF, Lo=0xFFFFFFF2; busy low in cycle 35.
- MULTU:
  - Stimulus: 0xFFFFFFFF×0xFFFFFFFF.
  - Response: Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV:
  - Stimulus: −7 (0xFFFFFFF9) / 2.
  - Response: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV boundary cases:
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
  - DIVU 5/0 gives Lo=0xFFFFFFFF, Hi=5.
- flush and ignored start:
  - Stimulus: flush in cycle 20 of a DIVU.
  - Response: IDLE next cycle, no hlWrite.
  - Stimulus: start pulse while busy.
  - Response: ignored, and the original result is unchanged.
